fetch_memory_responder: RTL and testbench

- Memory-side responder for the instruction-fetch read protocol. It accepts read requests (address plus BusID) from a fetch-stage initiator and returns 64-bit read-response packets.
- Backed by a word-addressed instruction store that a loader port preloads.
- Sits between the memory bus and the instruction RAM. It models a fixed read latency and holds each response until the initiator consumes it.

---
 rtl/fetch_memory_responder_pkg.sv | 19 +
 rtl/fetch_memory_responder_if.sv | 22 ++
 rtl/fetch_memory_responder_fetch_req_fifo.sv | 42 ++++
 rtl/fetch_memory_responder.sv | 132 +++++++++++++
 tb/tb_fetch_memory_responder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_memory_responder_pkg.sv
// fetch_memory_responder_pkg: shared bus types, responder FSM states and the queued request struct
package fetch_memory_responder_pkg;
  typedef logic [3:0] BusID;
  typedef enum logic [1:0] {
    bus_idle,
    bus_read_request,
    bus_read_response,
    bus_error_response
  } BusPacketType;
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} fetch_resp_state_t;
  localparam int INSN_WORD_BYTES = 8;
  typedef struct packed {
    logic [63:0] address;
    BusID        bus_id;
  } fetch_read_req_t;
  function automatic logic [63:0] align_addr(input logic [63:0] a);
    return a & ~64'(INSN_WORD_BYTES - 1);
  endfunction
endpackage

// File: rtl/fetch_memory_responder_if.sv
// fetch_memory_responder_if: fetch read request/response bus between initiator (master) and responder (slave)
interface fetch_memory_responder_if;
  import fetch_memory_responder_pkg::*;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_address;
  BusID         req_bus_id;
  logic         resp_valid;
  logic         resp_ready;
  BusPacketType resp_packet_type;
  logic [63:0]  resp_address;
  logic [63:0]  resp_payload;
  BusID         resp_bus_id;
  modport master (
    output req_valid, req_address, req_bus_id, resp_ready,
    input  req_ready, resp_valid, resp_packet_type, resp_address, resp_payload, resp_bus_id
  );
  modport slave (
    input  req_valid, req_address, req_bus_id, resp_ready,
    output req_ready, resp_valid, resp_packet_type, resp_address, resp_payload, resp_bus_id
  );
endinterface

// File: rtl/fetch_memory_responder_fetch_req_fifo.sv
// fetch_req_fifo: synchronous request queue; DEPTH must be a power of 2 so pointers wrap for free
module fetch_req_fifo
  import fetch_memory_responder_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_read_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = mem_q[rd_q];
  // entry storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;
  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push_i);
      rd_q  <= rd_q + PW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));
endmodule

// File: rtl/fetch_memory_responder.sv
// fetch_memory_responder: fixed-latency instruction-store read responder; optional FETCH_RESPONDER_PERF_COUNTERS_EN adds perf counters
module fetch_memory_responder
  import fetch_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int READ_LATENCY   = 2,
  parameter int REQ_FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  fetch_memory_responder_if.slave        bus,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_index,
  input  logic [63:0]                    load_data
`ifdef FETCH_RESPONDER_PERF_COUNTERS_EN
  ,
  output logic [31:0]                    perf_reads_served,
  output logic [31:0]                    perf_resp_stall_cycles,
  output logic [31:0]                    perf_req_backpressure_cycles
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(READ_LATENCY + 1);
  logic [63:0]       store_q [DEPTH_WORDS];
  fetch_read_req_t   req_in;
  fetch_read_req_t   head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              hd_err;
  logic [63:0]       hd_word;
  logic [CW-1:0]     lat_ld;
  fetch_resp_state_t state_q;
  logic [CW-1:0]     cnt_q;
  logic              valid_q;
  BusPacketType      type_q;
  logic [63:0]       addr_q;
  logic [63:0]       payload_q;
  BusID              id_q;
  logic              cap_err_q;
  logic [63:0]       cap_addr_q;
  logic [63:0]       cap_word_q;
  BusID              cap_id_q;
  assign req_in        = '{address: bus.req_address, bus_id: bus.req_bus_id};
  assign bus.req_ready = !full && !reset;
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = !empty && (state_q == IDLE || (state_q == RESPOND && bus.resp_ready));
  assign hd_err        = |head.address[63:3+AW];
  assign hd_word       = hd_err ? '0 : store_q[head.address[3 +: AW]];
  // a pop from RESPOND reuses the handshake cycle as the idle slot, so it waits one extra cycle
  assign lat_ld        = state_q == IDLE ? CW'(READ_LATENCY - 1) : CW'(READ_LATENCY);
  assign bus.resp_valid       = valid_q;
  assign bus.resp_packet_type = type_q;
  assign bus.resp_address     = addr_q;
  assign bus.resp_payload     = payload_q;
  assign bus.resp_bus_id      = id_q;
  fetch_req_fifo #(.DEPTH(REQ_FIFO_DEPTH), .T(fetch_read_req_t)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .din_i   (req_in),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // preload port; a capture of the same index in this cycle still sees the old word
  always_ff @(posedge clk) if (load_en) store_q[load_index] <= load_data;
  // service FSM: pop and capture, count down the latency, then present and hold the response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      type_q     <= bus_idle;
      addr_q     <= '0;
      payload_q  <= '0;
      id_q       <= '0;
      cap_err_q  <= 1'b0;
      cap_addr_q <= '0;
      cap_word_q <= '0;
      cap_id_q   <= '0;
    end else if (pop) begin
      cap_err_q  <= hd_err;
      cap_addr_q <= align_addr(head.address);
      cap_word_q <= hd_word;
      cap_id_q   <= head.bus_id;
      cnt_q      <= lat_ld;
      valid_q    <= lat_ld == '0;
      state_q    <= lat_ld == '0 ? RESPOND : WAIT;
      if (lat_ld == '0) begin
        type_q    <= hd_err ? bus_error_response : bus_read_response;
        addr_q    <= align_addr(head.address);
        payload_q <= hd_word;
        id_q      <= head.bus_id;
      end
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        valid_q   <= 1'b1;
        state_q   <= RESPOND;
        type_q    <= cap_err_q ? bus_error_response : bus_read_response;
        addr_q    <= cap_addr_q;
        payload_q <= cap_word_q;
        id_q      <= cap_id_q;
      end
    end else if (state_q == RESPOND && bus.resp_ready) begin
      valid_q <= 1'b0;
      state_q <= IDLE;
    end
  end
  a_resp_stable: assert property (@(posedge clk) disable iff (reset)
    valid_q && !bus.resp_ready |=> valid_q && $stable({type_q, addr_q, payload_q, id_q}));
`ifdef FETCH_RESPONDER_PERF_COUNTERS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && ~&v) ? v + 32'd1 : v;
  endfunction
  // saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads_served            <= '0;
      perf_resp_stall_cycles       <= '0;
      perf_req_backpressure_cycles <= '0;
    end else begin
      perf_reads_served            <= sat_inc(perf_reads_served, valid_q && bus.resp_ready);
      perf_resp_stall_cycles       <= sat_inc(perf_resp_stall_cycles, valid_q && !bus.resp_ready);
      perf_req_backpressure_cycles <= sat_inc(perf_req_backpressure_cycles, bus.req_valid && !bus.req_ready);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_memory_responder.sv
// tb_fetch_memory_responder: directed checks of latency, ordering, backpressure, reset and preload collision
module tb_fetch_memory_responder;
  import fetch_memory_responder_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [9:0]  load_index = '0;
  logic [63:0] load_data = '0;
  int          checks = 0;
  int          errors = 0;
  localparam logic [63:0] W5  = 64'hDEAD_BEEF_0000_0011;
  localparam logic [63:0] NEW = 64'h0123_4567_89AB_CDEF;
  fetch_memory_responder_if bus();
`ifdef FETCH_RESPONDER_PERF_COUNTERS_EN
  logic [31:0] p_served, p_stall, p_bp;
`endif
  fetch_memory_responder dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .load_en    (load_en),
    .load_index (load_index),
    .load_data  (load_data)
`ifdef FETCH_RESPONDER_PERF_COUNTERS_EN
    ,
    .perf_reads_served            (p_served),
    .perf_resp_stall_cycles       (p_stall),
    .perf_req_backpressure_cycles (p_bp)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] wv(input int i);
    return 64'h5A5A_0000_0000_0000 + 64'(i);
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic load(input int idx, input logic [63:0] d);
    load_en = 1'b1;
    load_index = 10'(idx);
    load_data = d;
    tick;
    load_en = 1'b0;
  endtask
  task automatic send(input logic [63:0] a, input logic [3:0] id);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_address = a;
    bus.req_bus_id = id;
    while (!bus.req_ready && n < 20) begin
      tick;
      n++;
    end
    check("req_accept_timeout", 64'(n < 20), 1);
    tick;
    bus.req_valid = 1'b0;
  endtask
  task automatic expect_resp(input logic [63:0] addr, input logic [63:0] pay, input BusPacketType t,
                             input logic [3:0] id, input int lat);
    int n = 0;
    while (!bus.resp_valid && n < 20) begin
      tick;
      n++;
    end
    check("latency", 64'(n), 64'(lat));
    check("resp_valid", 64'(bus.resp_valid), 1);
    check("resp_type", 64'(bus.resp_packet_type), 64'(t));
    check("resp_address", bus.resp_address, addr);
    check("resp_payload", bus.resp_payload, pay);
    check("resp_bus_id", 64'(bus.resp_bus_id), 64'(id));
    bus.resp_ready = 1'b1;
    tick;
    bus.resp_ready = 1'b0;
    check("valid_drop", 64'(bus.resp_valid), 0);
  endtask
  task automatic do_read(input logic [63:0] a, input logic [3:0] id, input logic [63:0] pay,
                         input BusPacketType t, input logic [63:0] ea);
    send(a, id);
    expect_resp(ea, pay, t, id, 2);
  endtask
  initial begin
    int got, last, pend, seen;
    bus.req_valid = 1'b0;
    bus.req_address = '0;
    bus.req_bus_id = '0;
    bus.resp_ready = 1'b0;
    tick;
    tick;
    check("rst_req_ready", 64'(bus.req_ready), 0);
    check("rst_resp_valid", 64'(bus.resp_valid), 0);
    check("rst_type", 64'(bus.resp_packet_type), 0);
    check("rst_address", bus.resp_address, 0);
    check("rst_payload", bus.resp_payload, 0);
    check("rst_bus_id", 64'(bus.resp_bus_id), 0);
    reset = 1'b0;
    tick;
    check("post_rst_ready", 64'(bus.req_ready), 1);
    load(5, W5);
    for (int i = 6; i <= 9; i++) load(i, wv(i));
    load(1023, wv(1023));
    do_read(64'h28, 4'd3, W5, bus_read_response, 64'h28);
    do_read(64'h2D, 4'd5, W5, bus_read_response, 64'h28);
    do_read(64'h2000, 4'd1, 64'h0, bus_error_response, 64'h2000);
    do_read(64'h1FF8, 4'd2, wv(1023), bus_read_response, 64'h1FF8);
    do_read(64'h8000_0000_0000_0028, 4'd4, 64'h0, bus_error_response, 64'h8000_0000_0000_0028);
    send(64'h30, 4'd6);
    send(64'h38, 4'd7);
    send(64'h40, 4'd8);
    bus.req_valid = 1'b1;
    bus.req_address = 64'h48;
    bus.req_bus_id = 4'd9;
    for (int i = 0; i < 8; i++) begin
      check("full_ready", 64'(bus.req_ready), 0);
      check("hold_valid", 64'(bus.resp_valid), 1);
      check("hold_payload", bus.resp_payload, wv(6));
      check("hold_bus_id", 64'(bus.resp_bus_id), 6);
      tick;
    end
    bus.resp_ready = 1'b1;
    got = 0;
    last = 0;
    pend = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (bus.resp_valid) begin
        check("order_bus_id", 64'(bus.resp_bus_id), 64'(6 + got));
        check("order_payload", bus.resp_payload, wv(6 + got));
        if (got > 0) check("cadence", 64'(c - last), 3);
        last = c;
        got++;
      end
      if (pend != 0) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) pend = 1;
      if (got < 4) tick;
    end
    check("served_count", 64'(got), 4);
    tick;
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("drained_valid", 64'(bus.resp_valid), 0);
    send(64'h28, 4'd3);
    send(64'h30, 4'd6);
    send(64'h38, 4'd7);
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_address = 64'h40;
    bus.req_bus_id = 4'd8;
    tick;
    bus.resp_ready = 1'b0;
    check("mid_handshake_drop", 64'(bus.resp_valid), 0);
    tick;
    bus.req_valid = 1'b0;
    check("queue_full_in_wait", 64'(bus.req_ready), 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.resp_valid) seen = 1;
      tick;
    end
    check("no_resp_after_reset", 64'(seen), 0);
    do_read(64'h28, 4'd3, W5, bus_read_response, 64'h28);
    send(64'h28, 4'd10);
    load_en = 1'b1;
    load_index = 10'd5;
    load_data = NEW;
    tick;
    load_en = 1'b0;
    expect_resp(64'h28, W5, bus_read_response, 4'd10, 1);
    do_read(64'h28, 4'd11, NEW, bus_read_response, 64'h28);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
